// File: rtl/render_fetch_if.sv
// Grid-memory read port between the pixel fetch engine and the double-buffered grid RAM.
// The fetch engine is the master; the RAM returns data exactly one cycle after a request.
interface render_fetch_if #(
    parameter int IDX_W  = 13,
    parameter int CELL_W = 11
);
    logic              mem_rd_en;
    logic [IDX_W:0]    mem_addr;
    logic [CELL_W-1:0] mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/render_fetch.sv
// Per-pixel grid-cell fetch for the color mapper.
// It reads the double-buffered grid memory, reuses the last cell while pixels stay in it, and swaps banks at frame start.
module render_fetch #(
    parameter int GRID_W      = 80,
    parameter int GRID_H      = 60,
    parameter int CELL_SHIFT  = 3,
    parameter int IDX_W       = 13,
    parameter int SIGNAL_bits = 8,
    parameter int CELL_W      = SIGNAL_bits + 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   pix_valid,
    input  logic                   frame_start,
    render_fetch_if.master         mem,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic                   read_bank,
    output logic                   renderSugar,
    output logic                   renderNest,
    output logic                   renderAnt,
    output logic [SIGNAL_bits-1:0] renderChem,
    output logic                   render_valid
);
    localparam logic [IDX_W-1:0] GRID_W_L = IDX_W'(GRID_W);
    localparam logic [IDX_W-1:0] GRID_H_L = IDX_W'(GRID_H);

    typedef enum logic [0:0] {ARMED = 1'b0, WAIT_LOW = 1'b1} swap_state_t;

    swap_state_t       state_r, state_nx_s;
    logic              swap_fire_s;
    logic              read_bank_r, swap_ack_r;

    logic [IDX_W-1:0]  col_s, row_s, idx_s;
    logic              inside_s, hit_s, rd_s;
    logic              last_ok_r;
    logic [IDX_W-1:0]  last_idx_r;

    logic              s1_valid_r, s1_rd_r, s1_in_r;
    logic [CELL_W-1:0] hold_r;
    logic              out_valid_r, out_ant_r, out_sugar_r, out_nest_r;
    logic [SIGNAL_bits-1:0] out_chem_r;

    // Stage 0: pixel to cell index, grid-bounds test and reuse-cache lookup.
    always_comb begin
        col_s    = IDX_W'(DrawX >> CELL_SHIFT);
        row_s    = IDX_W'(DrawY >> CELL_SHIFT);
        idx_s    = row_s * GRID_W_L + col_s;
        inside_s = pix_valid && (col_s < GRID_W_L) && (row_s < GRID_H_L);
        hit_s    = last_ok_r && (idx_s == last_idx_r);
        rd_s     = inside_s && !hit_s && !Reset;
    end

    assign mem.mem_rd_en = rd_s;
    assign mem.mem_addr  = {read_bank_r, idx_s};

    // Reuse cache: valid only across an unbroken run of in-grid pixels within one bank.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_ok_r  <= 1'b0;
            last_idx_r <= '0;
        end else begin
            if (swap_fire_s || !inside_s) begin
                last_ok_r <= 1'b0;
            end else begin
                last_ok_r <= 1'b1;
            end
            if (inside_s) begin
                last_idx_r <= idx_s;
            end else begin
                last_idx_r <= last_idx_r;
            end
        end
    end

    // Swap FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ARMED;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Swap FSM next state: after a swap, swap_req must drop before another is accepted.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ARMED: begin
                if (frame_start && swap_req) state_nx_s = WAIT_LOW;
                else                         state_nx_s = ARMED;
            end
            WAIT_LOW: begin
                if (!swap_req) state_nx_s = ARMED;
                else           state_nx_s = WAIT_LOW;
            end
            default: state_nx_s = ARMED;
        endcase
    end

    // Swap FSM output decode.
    always_comb begin
        swap_fire_s = 1'b0;
        case (state_r)
            ARMED:    swap_fire_s = frame_start && swap_req;
            WAIT_LOW: swap_fire_s = 1'b0;
            default:  swap_fire_s = 1'b0;
        endcase
    end

    // Bank select and acknowledge pulse; the bank flips on the same edge that raises the ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_bank_r <= 1'b0;
            swap_ack_r  <= 1'b0;
        end else begin
            swap_ack_r <= swap_fire_s;
            if (swap_fire_s) begin
                read_bank_r <= ~read_bank_r;
            end else begin
                read_bank_r <= read_bank_r;
            end
        end
    end

    // Stage 1: remember what was issued while the memory answers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_r <= 1'b0;
            s1_rd_r    <= 1'b0;
            s1_in_r    <= 1'b0;
        end else begin
            s1_valid_r <= pix_valid;
            s1_rd_r    <= rd_s;
            s1_in_r    <= inside_s;
        end
    end

    // Stage 2: fresh read data, held data for a reused cell, or blank outside the grid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_r      <= '0;
            out_valid_r <= 1'b0;
            out_ant_r   <= 1'b0;
            out_sugar_r <= 1'b0;
            out_nest_r  <= 1'b0;
            out_chem_r  <= '0;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_rd_r) begin
                hold_r      <= mem.mem_rdata;
                out_ant_r   <= mem.mem_rdata[CELL_W-1];
                out_sugar_r <= mem.mem_rdata[CELL_W-2];
                out_nest_r  <= mem.mem_rdata[CELL_W-3];
                out_chem_r  <= mem.mem_rdata[SIGNAL_bits-1:0];
            end else if (s1_in_r) begin
                hold_r      <= hold_r;
                out_ant_r   <= hold_r[CELL_W-1];
                out_sugar_r <= hold_r[CELL_W-2];
                out_nest_r  <= hold_r[CELL_W-3];
                out_chem_r  <= hold_r[SIGNAL_bits-1:0];
            end else begin
                hold_r      <= hold_r;
                out_ant_r   <= 1'b0;
                out_sugar_r <= 1'b0;
                out_nest_r  <= 1'b0;
                out_chem_r  <= '0;
            end
        end
    end

    assign swap_ack     = swap_ack_r;
    assign read_bank    = read_bank_r;
    assign render_valid = out_valid_r;
    assign renderAnt    = out_ant_r;
    assign renderSugar  = out_sugar_r;
    assign renderNest   = out_nest_r;
    assign renderChem   = out_chem_r;
endmodule

// File: tb/tb_render_fetch.sv
// Self-checking bench for render_fetch: directed cases from the test plan plus randomized streaming
// against a cell-level reference model of pixel -> bank/cell -> render data.
module tb_render_fetch;
    localparam int GRID_W = 80, GRID_H = 60, CELL_SHIFT = 3, IDX_W = 13;
    localparam int SIGNAL_bits = 8, CELL_W = SIGNAL_bits + 3;
    localparam int STRIDE = 1 << IDX_W;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset = 1'b1, pix_valid = 1'b0, frame_start = 1'b0, swap_req = 1'b0;
    logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
    logic swap_ack, read_bank, renderSugar, renderNest, renderAnt, render_valid;
    logic [SIGNAL_bits-1:0] renderChem;

    render_fetch_if #(.IDX_W(IDX_W), .CELL_W(CELL_W)) mem_bus ();

    render_fetch #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_SHIFT(CELL_SHIFT), .IDX_W(IDX_W),
                   .SIGNAL_bits(SIGNAL_bits), .CELL_W(CELL_W)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .frame_start(frame_start), .mem(mem_bus), .swap_req(swap_req), .swap_ack(swap_ack),
        .read_bank(read_bank), .renderSugar(renderSugar), .renderNest(renderNest),
        .renderAnt(renderAnt), .renderChem(renderChem), .render_valid(render_valid));

    // Grid RAM: answers one cycle after a request, returns garbage when not asked.
    logic [CELL_W-1:0] mem [0:2*STRIDE-1];
    int rd_count = 0;
    always @(posedge Clk) begin
        if (mem_bus.mem_rd_en) mem_bus.mem_rdata <= mem[mem_bus.mem_addr];
        else                   mem_bus.mem_rdata <= CELL_W'($urandom);
        if (mem_bus.mem_rd_en) rd_count <= rd_count + 1;
    end

    int tests = 0, failed = 0;

    // Reference model state
    bit m_bank = 0, m_armed = 1, m_lastok = 0, m_ack = 0;
    int m_lastidx = 0;
    bit s1_valid = 0, s1_in = 0;
    logic [CELL_W-1:0] s1_data = '0;
    bit e_valid = 0;
    logic [CELL_W-1:0] e_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_pix(input int x, input int y, input bit v);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid = v;
    endtask

    // Compare all DUT outputs against the model, then advance the model over one clock edge.
    task automatic cycle();
        int col, row, idx;
        bit in_g, exp_rd, fire;
        #1;
        col  = int'(DrawX) >> CELL_SHIFT;
        row  = int'(DrawY) >> CELL_SHIFT;
        idx  = row * GRID_W + col;
        in_g = pix_valid && col < GRID_W && row < GRID_H;
        exp_rd = !Reset && in_g && !(m_lastok && idx == m_lastidx);
        check("mem_rd_en", 32'(mem_bus.mem_rd_en), 32'(exp_rd));
        if (exp_rd) check("mem_addr", 32'(mem_bus.mem_addr), 32'(int'(m_bank) * STRIDE + idx));
        check("render_valid", 32'(render_valid), 32'(e_valid));
        check("renderAnt", 32'(renderAnt), 32'(e_data[CELL_W-1]));
        check("renderSugar", 32'(renderSugar), 32'(e_data[CELL_W-2]));
        check("renderNest", 32'(renderNest), 32'(e_data[CELL_W-3]));
        check("renderChem", 32'(renderChem), 32'(e_data[SIGNAL_bits-1:0]));
        check("read_bank", 32'(read_bank), 32'(m_bank));
        check("swap_ack", 32'(swap_ack), 32'(m_ack));
        if (Reset) begin
            m_bank = 0; m_armed = 1; m_lastok = 0; m_ack = 0;
            s1_valid = 0; s1_in = 0; s1_data = '0; e_valid = 0; e_data = '0;
        end else begin
            fire = m_armed && frame_start && swap_req;
            e_valid = s1_valid;
            e_data  = s1_in ? s1_data : '0;
            s1_valid = pix_valid;
            s1_in    = in_g;
            s1_data  = in_g ? mem[int'(m_bank) * STRIDE + idx] : '0;
            m_lastok = in_g && !fire;
            if (in_g) m_lastidx = idx;
            m_ack = fire;
            if (fire) begin
                m_bank = !m_bank;
                m_armed = 0;
            end else if (!m_armed && !swap_req) begin
                m_armed = 1;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    int rd0, x, y;

    initial begin
        for (int i = 0; i < 2 * STRIDE; i++) mem[i] = CELL_W'($urandom);
        mem[82] = {1'b1, 1'b0, 1'b1, 8'h1F};
        mem_bus.mem_rdata = '0;

        // Initial reset edge (DUT state unknown before it), then check reset values.
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        set_pix(17, 9, 1'b1);
        #1 check("rd_en_in_reset", 32'(mem_bus.mem_rd_en), 32'd0);
        cycle();
        Reset = 1'b0;

        // Address map
        set_pix(17, 9, 1'b1);
        #1 check("addr_82", 32'(mem_bus.mem_addr), 32'd82);
        check("rd_82", 32'(mem_bus.mem_rd_en), 32'd1);
        cycle();
        set_pix(0, 0, 1'b0);
        cycle();

        // Reuse across one 8-pixel cell
        rd0 = rd_count;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_pix(16 + i, 9, 1'b1);
            else       set_pix(0, 0, 1'b0);
            if (i >= 2) begin
                #1;
                check("reuse_valid", 32'(render_valid), 32'd1);
                check("reuse_ant", 32'(renderAnt), 32'd1);
                check("reuse_nest", 32'(renderNest), 32'd1);
                check("reuse_sugar", 32'(renderSugar), 32'd0);
                check("reuse_chem", 32'(renderChem), 32'h1F);
            end
            cycle();
        end
        check("reuse_read_count", 32'(rd_count - rd0), 32'd1);

        // Out of grid, column then row
        for (int k = 0; k < 2; k++) begin
            set_pix(20, 9, 1'b1);
            cycle();
            if (k == 0) set_pix(645, 9, 1'b1);
            else        set_pix(20, 480, 1'b1);
            #1 check("oog_no_read", 32'(mem_bus.mem_rd_en), 32'd0);
            cycle();
            set_pix(21, 9, 1'b1);
            #1 check("oog_reread", 32'(mem_bus.mem_rd_en), 32'd1);
            cycle();
            set_pix(0, 0, 1'b0);
            #1;
            check("oog_valid", 32'(render_valid), 32'd1);
            check("oog_flags", 32'({renderAnt, renderSugar, renderNest, renderChem}), 32'd0);
            cycle();
        end

        // Swap handshake
        swap_req = 1'b1;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        #1 check("swap1_bank", 32'(read_bank), 32'd1);
        check("swap1_ack", 32'(swap_ack), 32'd1);
        set_pix(17, 9, 1'b1);
        #1 check("addr_8274", 32'(mem_bus.mem_addr), 32'd8274);
        cycle();
        set_pix(0, 0, 1'b0);
        #1 check("ack_one_cycle", 32'(swap_ack), 32'd0);
        cycle();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        #1 check("held_req_bank", 32'(read_bank), 32'd1);
        check("held_req_ack", 32'(swap_ack), 32'd0);
        cycle();
        swap_req = 1'b0;
        cycle();
        swap_req = 1'b1;
        cycle();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        #1 check("swap2_bank", 32'(read_bank), 32'd0);
        check("swap2_ack", 32'(swap_ack), 32'd1);
        cycle();

        // Mid-frame swap coincident with an in-grid pixel
        swap_req = 1'b0;
        cycle();
        swap_req = 1'b1;
        frame_start = 1'b1;
        set_pix(40, 0, 1'b1);
        #1 check("mid_addr_old", 32'(mem_bus.mem_addr), 32'd5);
        check("mid_rd_old", 32'(mem_bus.mem_rd_en), 32'd1);
        cycle();
        frame_start = 1'b0;
        set_pix(41, 0, 1'b1);
        #1 check("mid_addr_new", 32'(mem_bus.mem_addr), 32'd8197);
        check("mid_rd_new", 32'(mem_bus.mem_rd_en), 32'd1);
        cycle();
        swap_req = 1'b0;

        // Reset mid-stream
        set_pix(100, 100, 1'b1);
        cycle();
        Reset = 1'b1;
        set_pix(108, 100, 1'b1);
        cycle();
        Reset = 1'b0;
        set_pix(116, 100, 1'b1);
        #1 check("rst_valid", 32'(render_valid), 32'd0);
        check("rst_bank", 32'(read_bank), 32'd0);
        check("rst_flags", 32'({renderAnt, renderSugar, renderNest, renderChem}), 32'd0);
        cycle();

        // Randomized streaming with cell runs, off-grid spans, swaps and occasional reset
        x = 0;
        y = 0;
        for (int n = 0; n < 4000; n++) begin
            Reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 3) begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, 520);
            end else begin
                x = x + 1;
                if (x > 660) begin
                    x = 0;
                    y = (y + 1) % 525;
                end
            end
            set_pix(x, y, ($urandom_range(0, 9) != 0));
            frame_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) swap_req = ~swap_req;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
